tx_dual_arbiter_module: RTL and testbench
=========================================

Name: tx_dual_arbiter_module

Overview:
- Shares one UART TX engine between two independent TX FIFOs (channel 0, channel 1).
- Round-robin arbitration; one byte per grant.
- Sequence per grant: pops one byte from the granted FIFO, latches it, drives the TX engine enable and waits for TX_Done.
- Sits between the two TX FIFOs and the single tx module. A watchdog recovers from a missing TX_Done.

Parameters:
- TIMEOUT_CYCLES, 16'd60000: maximum cycles in SEND without TX_Done before abort. Must be at least one 10-bit frame time.
- GAP_CYCLES, 4'd2: idle cycles inserted after each completed byte before the next arbitration (min 0).

Ports:
- CLK  input  1  system clock
- RSTn  input  1  asynchronous active-low reset
- Empty_Sig0  input  1  channel 0 FIFO empty
- FIFO_Read_Data0  input  8  channel 0 FIFO read data, valid the cycle after a Read_Req0-high cycle
- Read_Req_Sig0  output  1  channel 0 FIFO pop strobe
- Empty_Sig1  input  1  channel 1 FIFO empty
- FIFO_Read_Data1  input  8  channel 1 FIFO read data, same timing as channel 0
- Read_Req_Sig1  output  1  channel 1 FIFO pop strobe
- TX_Done_Sig  input  1  one-cycle pulse from TX engine at end of stop bit
- TX_Data  output  8  registered byte to TX engine
- TX_En_Sig  output  1  TX engine enable, held until done
- Grant  output  2  one-hot current owner (01 = ch0, 10 = ch1, 00 = none)
- Timeout_Err  output  1  sticky watchdog flag

Behaviour:
- Reset (async, RSTn low): state IDLE; Read_Req_Sig0/1 = 0; TX_En_Sig = 0; TX_Data = 8'h00; Grant = 00; Timeout_Err = 0; last-served pointer = ch1, so ch0 wins the first tie; counters = 0.
- All outputs are registered. Reset mid-transfer drops TX_En immediately; the byte already popped is lost (accepted).
- State IDLE:
  - Neither FIFO non-empty: stay.
  - Exactly one non-empty: grant it.
  - Both non-empty: grant the channel not served last.
  - On grant: set Grant and go to READ.
- State READ (1 cycle): assert Read_Req of the granted channel only, for exactly one cycle → LATCH.
- State LATCH (1 cycle): Read_Req = 0. The FIFO data becomes valid this cycle; capture it into TX_Data at the end of the cycle → SEND.
- State SEND:
  - Assert TX_En_Sig; TX_Data is held stable; the watchdog counts.
  - On TX_Done_Sig: TX_En = 0, update last-served pointer, Grant = 00, clear watchdog → GAP.
  - If the watchdog reaches TIMEOUT_CYCLES-1 without TX_Done: TX_En = 0, Timeout_Err = 1, pointer updated as if sent → GAP.
  - TX_Done in the same cycle as timeout expiry: treat as success; Timeout_Err is not set.
- State GAP: count GAP_CYCLES cycles, then → IDLE. With GAP_CYCLES = 0, go directly to IDLE next cycle.
- TX_Done_Sig outside SEND: ignored.
- Empty flags are sampled only in IDLE. The FIFO must not be read while empty; arbitration guarantees this.
- Timeout_Err is cleared only by reset.
- Throughput: minimum 3 + GAP_CYCLES control cycles plus the frame time per byte.
- Fairness: with both channels continuously non-empty, grants strictly alternate 0,1,0,1…
- Counter widths: watchdog 16 bits; gap counter 4 bits; no wrap is possible within legal parameter ranges.

Optional Feature:
- Macro TX_CH_TAG_EN.
- Defined:
  - Each data byte is preceded by a tag byte 8'hA0 | channel (8'hA0 for ch0, 8'hA1 for ch1).
  - Extra states TAG_SEND and TAG_GAP are inserted after LATCH. The tag is sent with the same TX_En/TX_Done handshake and watchdog.
  - The data byte waits in a holding register while the tag is sent.
  - A timeout on the tag aborts both the tag and the data byte.
  - Grant remains asserted across both bytes.
- Not defined: no tag states; a single byte per grant exactly as above.

Test Plan:
- Ch0 holds 8'h55, ch1 empty → Read_Req0 single-cycle pulse; TX_Data = 8'h55 with TX_En high until a TX_Done pulse; Grant = 01 during the transfer; Read_Req1 never asserted.
- Both FIFOs hold 3 bytes each (ch0 11,12,13; ch1 21,22,23) → TX order 11,21,12,22,13,23; exactly 6 pops.
- TIMEOUT_CYCLES = 20, TX_Done never pulses → TX_En drops after 20 SEND cycles; Timeout_Err = 1 and stays 1; the next byte from the other channel proceeds normally.
- TX_Done arrives on the exact cycle of timeout expiry → no Timeout_Err; normal completion.
- RSTn pulsed low during SEND → TX_En, Grant and Read_Reqs go 0 asynchronously; after release, the next grant goes to ch0 on a tie.
- TX_CH_TAG_EN defined, ch1 holds 8'h3C → TX sequence A1, 3C; Grant = 10 throughout; one pop only.

Source files
------------

// File: rtl/tx_dual_arbiter_module.sv
// Round-robin sharing of one UART TX engine between two TX FIFOs.
// One byte per grant, TX_Done handshake, sticky watchdog abort flag.
//
// Ports:
//   CLK, RSTn          clock, async active-low reset
//   Empty_Sig0/1       FIFO empty flags (sampled in IDLE only)
//   FIFO_Read_Data0/1  FIFO data, valid the cycle after a pop
//   Read_Req_Sig0/1    one-cycle FIFO pop strobes
//   TX_Done_Sig        end-of-frame pulse from the TX engine
//   TX_Data, TX_En_Sig byte and enable to the TX engine
//   Grant              one-hot owner (01 ch0, 10 ch1, 00 none)
//   Timeout_Err        sticky watchdog flag, cleared by reset
//
// Optional: define TX_CH_TAG_EN to send a tag byte 8'hA0|ch
// ahead of every data byte within the same grant.
module tx_dual_arbiter_module #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd60000,
  parameter logic [3:0]  GAP_CYCLES     = 4'd2
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Empty_Sig0,
  input  logic [7:0] FIFO_Read_Data0,
  output logic       Read_Req_Sig0,
  input  logic       Empty_Sig1,
  input  logic [7:0] FIFO_Read_Data1,
  output logic       Read_Req_Sig1,
  input  logic       TX_Done_Sig,
  output logic [7:0] TX_Data,
  output logic       TX_En_Sig,
  output logic [1:0] Grant,
  output logic       Timeout_Err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
`ifdef TX_CH_TAG_EN
  localparam logic [2:0] S_TSEND = 3'd5;
  localparam logic [2:0] S_TGAP  = 3'd6;
`endif

  localparam logic [15:0] TMO_LAST =
    TIMEOUT_CYCLES - 16'd1;

  logic [2:0]  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        rr0_q, rr0_d;
  logic        rr1_q, rr1_d;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        terr_q, terr_d;
  logic        last_q, last_d;
  logic [15:0] wd_q, wd_d;
  logic [3:0]  gap_q, gap_d;
`ifdef TX_CH_TAG_EN
  logic [7:0]  hold_q, hold_d;
`endif

  logic [7:0] fifo_data;
  logic       wd_expired;
  logic       gap_done;

  assign fifo_data  = grant_q[1] ? FIFO_Read_Data1
                                 : FIFO_Read_Data0;
  assign wd_expired = (wd_q == TMO_LAST);
  // true on the last gap cycle; with GAP_CYCLES = 0 any
  // gap-type state lasts exactly one cycle
  assign gap_done   = ({1'b0, gap_q} + 5'd1) >=
                      {1'b0, GAP_CYCLES};

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr0_d     = 1'b0;
    rr1_d     = 1'b0;
    tx_en_d   = tx_en_q;
    tx_data_d = tx_data_q;
    terr_d    = terr_q;
    last_d    = last_q;
    wd_d      = wd_q;
    gap_d     = gap_q;
`ifdef TX_CH_TAG_EN
    hold_d    = hold_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // ch0 wins unless ch1 alone is ready or ch0 went last
        if (!Empty_Sig0 && (Empty_Sig1 || last_q)) begin
          grant_d = 2'b01;
          rr0_d   = 1'b1;
          state_d = S_READ;
        end else if (!Empty_Sig1) begin
          grant_d = 2'b10;
          rr1_d   = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        tx_en_d = 1'b1;
        wd_d    = 16'd0;
`ifdef TX_CH_TAG_EN
        hold_d    = fifo_data;
        tx_data_d = 8'hA0 | {7'd0, grant_q[1]};
        state_d   = S_TSEND;
`else
        tx_data_d = fifo_data;
        state_d   = S_SEND;
`endif
      end
      S_SEND: begin
        if (TX_Done_Sig || wd_expired) begin
          // a done pulse on the expiry cycle wins
          if (!TX_Done_Sig) terr_d = 1'b1;
          tx_en_d = 1'b0;
          grant_d = 2'b00;
          last_d  = grant_q[1];
          wd_d    = 16'd0;
          gap_d   = 4'd0;
          state_d = (GAP_CYCLES == 4'd0) ? S_IDLE : S_GAP;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      S_GAP: begin
        if (gap_done) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
`ifdef TX_CH_TAG_EN
      S_TSEND: begin
        if (TX_Done_Sig) begin
          tx_en_d = 1'b0;
          wd_d    = 16'd0;
          gap_d   = 4'd0;
          state_d = S_TGAP;
        end else if (wd_expired) begin
          // tag lost: drop the held data byte too
          terr_d  = 1'b1;
          tx_en_d = 1'b0;
          grant_d = 2'b00;
          last_d  = grant_q[1];
          wd_d    = 16'd0;
          gap_d   = 4'd0;
          state_d = (GAP_CYCLES == 4'd0) ? S_IDLE : S_GAP;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      S_TGAP: begin
        // enable always drops for at least one cycle
        if (gap_done) begin
          tx_data_d = hold_q;
          tx_en_d   = 1'b1;
          wd_d      = 16'd0;
          state_d   = S_SEND;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
        tx_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= S_IDLE;
      grant_q   <= 2'b00;
      rr0_q     <= 1'b0;
      rr1_q     <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      terr_q    <= 1'b0;
      last_q    <= 1'b1;
      wd_q      <= 16'd0;
      gap_q     <= 4'd0;
`ifdef TX_CH_TAG_EN
      hold_q    <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr0_q     <= rr0_d;
      rr1_q     <= rr1_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      terr_q    <= terr_d;
      last_q    <= last_d;
      wd_q      <= wd_d;
      gap_q     <= gap_d;
`ifdef TX_CH_TAG_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign Read_Req_Sig0 = rr0_q;
  assign Read_Req_Sig1 = rr1_q;
  assign TX_En_Sig     = tx_en_q;
  assign TX_Data       = tx_data_q;
  assign Grant         = grant_q;
  assign Timeout_Err   = terr_q;

endmodule

// File: tb/tb_tx_dual_arbiter_module.sv
// Bench for tx_dual_arbiter_module: FIFO and TX engine models
// plus a round-robin reference of the expected byte stream.
module tb_tx_dual_arbiter_module;

  localparam int TMO = 20;
  localparam int GAP = 2;
`ifdef TX_CH_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    bit         ch;
    bit         to;
    bit         fin;
  } ep_t;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       Empty_Sig0 = 1'b1;
  logic [7:0] FIFO_Read_Data0 = 8'h00;
  logic       Read_Req_Sig0;
  logic       Empty_Sig1 = 1'b1;
  logic [7:0] FIFO_Read_Data1 = 8'h00;
  logic       Read_Req_Sig1;
  logic       TX_Done_Sig = 1'b0;
  logic [7:0] TX_Data;
  logic       TX_En_Sig;
  logic [1:0] Grant;
  logic       Timeout_Err;

  int errors = 0;
  int checks = 0;

  logic [7:0] q0[$], q1[$];
  logic [7:0] d0[$], d1[$];
  logic [7:0] m0[$], m1[$];
  ep_t        exp_q[$];

  bit pend0, pend1;
  bit prev_en, prev_rr0, prev_rr1;
  bit cur_dead, gap_arm, exp_terr;
  bit last_m = 1'b1;
  int en_len, frame, dead_left, gap_cnt;
  int pops0, pops1, g0, g1;

  always #5 CLK = ~CLK;

  tx_dual_arbiter_module #(
    .TIMEOUT_CYCLES(16'd20),
    .GAP_CYCLES(4'd2)
  ) dut (
    .CLK(CLK),
    .RSTn(RSTn),
    .Empty_Sig0(Empty_Sig0),
    .FIFO_Read_Data0(FIFO_Read_Data0),
    .Read_Req_Sig0(Read_Req_Sig0),
    .Empty_Sig1(Empty_Sig1),
    .FIFO_Read_Data1(FIFO_Read_Data1),
    .Read_Req_Sig1(Read_Req_Sig1),
    .TX_Done_Sig(TX_Done_Sig),
    .TX_Data(TX_Data),
    .TX_En_Sig(TX_En_Sig),
    .Grant(Grant),
    .Timeout_Err(Timeout_Err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  // one clock: FIFO + TX engine responders and checks
  task automatic tick();
    ep_t e;
    @(posedge CLK);
    #1;
    TX_Done_Sig = 1'b0;
    if (pend0) begin
      FIFO_Read_Data0 = q0.pop_front();
      pend0 = 1'b0;
      Empty_Sig0 = (q0.size() == 0);
    end
    if (pend1) begin
      FIFO_Read_Data1 = q1.pop_front();
      pend1 = 1'b0;
      Empty_Sig1 = (q1.size() == 0);
    end
    chk("rr_both", Read_Req_Sig0 & Read_Req_Sig1, 0);
    chk("rr0_pulse", Read_Req_Sig0 & prev_rr0, 0);
    chk("rr1_pulse", Read_Req_Sig1 & prev_rr1, 0);
    if (Read_Req_Sig0 || Read_Req_Sig1) begin
      if (gap_arm) chk("gap_len", gap_cnt, GAP + 1);
      gap_arm = 1'b0;
    end else if (gap_arm) begin
      gap_cnt++;
    end
    if (Read_Req_Sig0) begin
      chk("rr0_owner", Grant, 2'b01);
      chk("pop0_avail", q0.size() != 0, 1);
      if (q0.size() != 0) pend0 = 1'b1;
      pops0++;
    end
    if (Read_Req_Sig1) begin
      chk("rr1_owner", Grant, 2'b10);
      chk("pop1_avail", q1.size() != 0, 1);
      if (q1.size() != 0) pend1 = 1'b1;
      pops1++;
    end
    if (TX_En_Sig) begin
      if (!prev_en) begin
        en_len = 0;
        cur_dead = (dead_left > 0);
        if (cur_dead) dead_left--;
      end
      en_len++;
      chk("tx_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        chk("tx_data", TX_Data, exp_q[0].data);
        chk("tx_grant", Grant,
            exp_q[0].ch ? 2'b10 : 2'b01);
      end
      if (!cur_dead && en_len == frame)
        TX_Done_Sig = 1'b1;
    end else if (prev_en && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("en_len", en_len, e.to ? TMO : frame);
      if (e.to) exp_terr = 1'b1;
      chk("grant_after", Grant,
          e.fin ? 2'b00 : (e.ch ? 2'b10 : 2'b01));
      if (e.fin) begin
        gap_arm = 1'b1;
        gap_cnt = 1;
      end
    end
    chk("timeout_err", Timeout_Err, exp_terr);
    prev_en  = TX_En_Sig;
    prev_rr0 = Read_Req_Sig0;
    prev_rr1 = Read_Req_Sig1;
  endtask

  // reference: round robin over d0/d1, first dd episodes
  // never see TX_Done
  task automatic load(input int dd);
    logic [7:0] b;
    bit ch, de;
    int ep;
    ep = 0;
    g0 = 0;
    g1 = 0;
    m0 = d0;
    m1 = d1;
    while (m0.size() + m1.size() != 0) begin
      if (m0.size() != 0 && m1.size() != 0)
        ch = !last_m;
      else
        ch = (m0.size() == 0);
      b = ch ? m1.pop_front() : m0.pop_front();
      if (ch) g1++;
      else g0++;
      last_m = ch;
      if (TAG) begin
        de = (ep < dd);
        ep++;
        exp_q.push_back('{8'hA0 | {7'd0, ch}, ch, de, de});
        if (de) continue;
      end
      de = (ep < dd);
      ep++;
      exp_q.push_back('{b, ch, de, 1'b1});
    end
    foreach (d0[i]) q0.push_back(d0[i]);
    foreach (d1[i]) q1.push_back(d1[i]);
    dead_left = dd;
    pops0 = 0;
    pops1 = 0;
    gap_arm = 1'b0;
    Empty_Sig0 = (q0.size() == 0);
    Empty_Sig1 = (q1.size() == 0);
  endtask

  task automatic run_scn(input int fl, input int dd);
    int budget;
    frame = fl;
    load(dd);
    budget = 0;
    while (exp_q.size() != 0 && budget < 3000) begin
      tick();
      budget++;
    end
    chk("scn_budget", exp_q.size() == 0, 1);
    exp_q.delete();
    repeat (GAP + 3) tick();
    chk("pops0", pops0, g0);
    chk("pops1", pops1, g1);
    chk("fifo_drained", q0.size() + q1.size(), 0);
    chk("idle_grant", Grant, 2'b00);
    chk("idle_en", TX_En_Sig, 0);
    dead_left = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n0, n1, b;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_grant", Grant, 2'b00);
    chk("rst_en", TX_En_Sig, 0);
    chk("rst_rr", {Read_Req_Sig0, Read_Req_Sig1}, 0);
    chk("rst_data", TX_Data, 8'h00);
    chk("rst_terr", Timeout_Err, 0);
    RSTn = 1'b1;

    d0 = '{8'h11, 8'h12, 8'h13};
    d1 = '{8'h21, 8'h22, 8'h23};
    run_scn(6, 0);

    d0 = '{8'h55};
    d1.delete();
    run_scn(10, 0);

    d0 = '{8'h5A};
    d1 = '{8'hA5};
    run_scn(TMO, 0);

    d0 = '{8'h01};
    d1 = '{8'h02};
    run_scn(8, 1);

    TX_Done_Sig = 1'b1;
    tick();
    chk("idle_done_ignored",
        {Grant, TX_En_Sig, Read_Req_Sig0, Read_Req_Sig1}, 0);

    for (int k = 0; k < 5; k++) begin
      n0 = $urandom_range(4);
      n1 = $urandom_range(4);
      d0.delete();
      d1.delete();
      for (int i = 0; i < n0; i++)
        d0.push_back(8'($urandom_range(255)));
      for (int i = 0; i < n1; i++)
        d1.push_back(8'($urandom_range(255)));
      run_scn($urandom_range(20, 1), $urandom_range(1));
    end

    d0.delete();
    d1 = '{8'h3C};
    run_scn(5, 0);

    d0 = '{8'h77};
    d1.delete();
    run_scn(6, 0);

    d0.delete();
    d1 = '{8'h99};
    frame = 15;
    load(0);
    b = 0;
    while (!(TX_En_Sig && en_len >= 3) && b < 200) begin
      tick();
      b++;
    end
    chk("rst_reached_send", TX_En_Sig, 1);
    #2 RSTn = 1'b0;
    #1;
    chk("arst_en", TX_En_Sig, 0);
    chk("arst_grant", Grant, 2'b00);
    chk("arst_rr", {Read_Req_Sig0, Read_Req_Sig1}, 0);
    chk("arst_data", TX_Data, 8'h00);
    chk("arst_terr", Timeout_Err, 0);
    exp_q.delete();
    q0.delete();
    q1.delete();
    pend0 = 1'b0;
    pend1 = 1'b0;
    prev_en = 1'b0;
    exp_terr = 1'b0;
    last_m = 1'b1;
    gap_arm = 1'b0;
    Empty_Sig0 = 1'b1;
    Empty_Sig1 = 1'b1;
    repeat (2) tick();
    RSTn = 1'b1;
    tick();

    d0 = '{8'hC0};
    d1 = '{8'hC1};
    run_scn(7, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
